// File: rtl/pkt_emptylist.sv
// Free-slot list for the packet buffer: a circular FIFO of slot IDs, filled with 0..NUM_SLOTS-1 after reset.
// Optional double-release detection is enabled by defining EMPTYLIST_DUP_CHECK_EN.
module pkt_emptylist #(
    parameter int NUM_SLOTS = 512,
    parameter int SLOT_W    = 9
) (
    input  logic              clk,
    input  logic              rst,
    output logic [SLOT_W-1:0] emptylist_out_data,
    output logic              emptylist_out_valid,
    input  logic              emptylist_out_ready,
    input  logic [SLOT_W-1:0] release_in_data,
    input  logic              release_in_valid,
    output logic              release_in_ready,
    output logic              init_done,
    output logic [SLOT_W:0]   free_count,
    output logic [31:0]       stats_alloc,
    output logic              dup_err
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [SLOT_W:0]   FULL_COUNT = (SLOT_W+1)'(NUM_SLOTS);
    localparam logic [SLOT_W:0]   COUNT_ONE  = (SLOT_W+1)'(1);
    localparam logic [SLOT_W-1:0] LAST_ID    = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0] PTR_ONE    = SLOT_W'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [SLOT_W-1:0] rd_ptr_r;
    logic [SLOT_W-1:0] wr_ptr_r;
    logic [SLOT_W-1:0] rd_ptr_nxt_s;
    logic [SLOT_W-1:0] wr_ptr_nxt_s;
    logic [SLOT_W:0]   count_r;
    logic [SLOT_W:0]   count_nxt_s;
    logic [SLOT_W-1:0] mem_r [NUM_SLOTS];
    logic              out_valid_r;
    logic              rel_ready_r;
    logic              init_done_r;
    logic              out_valid_nxt_s;
    logic              rel_ready_nxt_s;
    logic              init_done_nxt_s;
    logic [31:0]       stats_r;
    logic              alloc_s;
    logic              accept_s;
    logic              dup_s;
    logic              wr_en_s;
    logic [SLOT_W-1:0] wr_data_s;

    assign alloc_s  = out_valid_r && emptylist_out_ready;
    assign accept_s = release_in_valid && rel_ready_r;

`ifdef EMPTYLIST_DUP_CHECK_EN
    logic [NUM_SLOTS-1:0] free_bm_r;
    logic                 dup_err_r;

    // A release of the slot being allocated this very cycle counts as a double release too.
    assign dup_s = accept_s &&
                   (free_bm_r[release_in_data] ||
                    (alloc_s && (release_in_data == emptylist_out_data)));

    // Free bitmap: set when an ID enters the FIFO, cleared when it is handed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_bm_r <= '0;
            dup_err_r <= 1'b0;
        end else begin
            if (alloc_s) begin
                free_bm_r[emptylist_out_data] <= 1'b0;
            end
            if (wr_en_s) begin
                free_bm_r[wr_data_s] <= 1'b1;
            end
            dup_err_r <= dup_s;
        end
    end

    assign dup_err = dup_err_r;
`else
    assign dup_s   = 1'b0;
    assign dup_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: INIT ends once the last slot ID has been written.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (wr_ptr_r == LAST_ID) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Output/datapath logic: FIFO write source, pointer/count updates and next handshake levels.
    always_comb begin
        wr_en_s      = 1'b0;
        wr_data_s    = release_in_data;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        case (state_r)
            ST_INIT: begin
                wr_en_s   = 1'b1;
                wr_data_s = wr_ptr_r;
            end
            ST_RUN: begin
                wr_en_s   = accept_s && !dup_s;
                wr_data_s = release_in_data;
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_data_s = release_in_data;
            end
        endcase
        if (alloc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        case ({alloc_s, wr_en_s})
            2'b10:   count_nxt_s = count_r - COUNT_ONE;
            2'b01:   count_nxt_s = count_r + COUNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        // Handshake levels are registered from next state so they match count in the same cycle.
        init_done_nxt_s = (state_nxt_s == ST_RUN);
        out_valid_nxt_s = (state_nxt_s == ST_RUN) && (count_nxt_s != '0);
        rel_ready_nxt_s = (state_nxt_s == ST_RUN) && (count_nxt_s != FULL_COUNT);
    end

    // Pointers, count, statistics and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            stats_r     <= 32'd0;
            out_valid_r <= 1'b0;
            rel_ready_r <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            stats_r     <= alloc_s ? (stats_r + 32'd1) : stats_r;
            out_valid_r <= out_valid_nxt_s;
            rel_ready_r <= rel_ready_nxt_s;
            init_done_r <= init_done_nxt_s;
        end
    end

    // Slot ID storage; contents are meaningless after reset until rewritten by INIT.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_data_s;
        end
    end

    assign emptylist_out_data  = mem_r[rd_ptr_r];
    assign emptylist_out_valid = out_valid_r;
    assign release_in_ready    = rel_ready_r;
    assign init_done           = init_done_r;
    assign free_count          = count_r;
    assign stats_alloc         = stats_r;

endmodule
